// File: rtl/memoria_compartilhada.sv
// Shared memory behind a coherence bus: 16 x 10-bit blocks served with a fixed
// latency, plus an edge-triggered write-back port that can bypass into a response.
module memoria_compartilhada #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] bus_in,
    input  logic        wb,
    input  logic [15:0] wb_block,
    output logic [15:0] data_mem,
    output logic        mem_valid,
    output logic        busy,
    output logic [7:0]  rd_count,
    output logic [7:0]  wr_count
);

    typedef enum logic [1:0] {IDLE, FETCH, RESP, HOLD} state_t;

    typedef struct packed {
        logic [1:0] msg;
        logic [3:0] tag;
        logic [9:0] rsvd;
    } bus_req_t;

    localparam logic [1:0] MSG_RD_MISS = 2'b00;
    localparam logic [1:0] MSG_WR_MISS = 2'b01;
    localparam logic [3:0] LAT_INIT    = 4'(MEM_LATENCY);

    state_t     state;
    bus_req_t   bus_req;
    bus_req_t   req_q;
    logic [3:0] lat_cnt;
    logic [9:0] mem [16];
    logic       wb_prev;
    logic       wb_rise;
    logic [3:0] wb_tag;
    logic [9:0] wb_data;
    logic [9:0] rd_data;
    logic       req_match;

    assign bus_req   = bus_req_t'(bus_in);
    assign wb_rise   = wb & ~wb_prev;
    assign wb_tag    = wb_block[15:12];
    assign wb_data   = wb_block[9:0];
    assign req_match = (bus_in == 16'(req_q));
    assign busy      = (state != IDLE);

    // A write-back landing on the response edge must be visible in that response.
    assign rd_data = (wb_rise && (wb_tag == req_q.tag)) ? wb_data : mem[req_q.tag];

    always_ff @(posedge clock) begin
        if (!reset) wb_prev <= 1'b0;
        else        wb_prev <= wb;
    end

    // Only write-back ever modifies the array; reset reloads the t+1 pattern.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int t = 0; t < 16; t++) mem[t] <= 10'(t + 1);
        end else if (wb_rise) begin
            mem[wb_tag] <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            req_q     <= '0;
            lat_cnt   <= '0;
            data_mem  <= '0;
            mem_valid <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_in != 16'h0000) begin
                        req_q <= bus_req;
                        if (!bus_req.msg[1]) begin
                            state   <= FETCH;
                            lat_cnt <= LAT_INIT;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                FETCH: begin
                    // A changed bus abandons the miss before anything is counted.
                    if (!req_match) begin
                        state <= IDLE;
                    end else if (lat_cnt <= 4'd1) begin
                        data_mem  <= {req_q.tag, 2'b00, rd_data};
                        mem_valid <= 1'b1;
                        state     <= RESP;
                        if (req_q.msg == MSG_RD_MISS && rd_count != 8'hFF)
                            rd_count <= rd_count + 8'd1;
                        if (req_q.msg == MSG_WR_MISS && wr_count != 8'hFF)
                            wr_count <= wr_count + 8'd1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!req_match) begin
                        data_mem  <= '0;
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (!req_match) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
